// File: rtl/cray_v_pkg.sv
// Shared definitions for the vector reservation logic.
//   - FU encodings (the bit position of each unit in the one-hot FU strobes)
//   - Vector-length constants and derived counter widths
//   - Write-FSM state encoding
//   - eff_len(): maps a raw VL input to the length a reservation actually runs for
package cray_v_pkg;

    localparam int MAXVL  = 64;
    localparam int VL_W   = 7;
    // Counter wide enough to hold MAXVL itself (a length), and an element index 0..MAXVL-1.
    localparam int LEN_W  = $clog2(MAXVL + 1);
    localparam int ELEM_W = $clog2(MAXVL);
    localparam int DLY_W  = 4;

    typedef enum logic [2:0] {
        FU_VLOG   = 3'd0,
        FU_VSHIFT = 3'd1,
        FU_VADD   = 3'd2,
        FU_FP_MUL = 3'd3,
        FU_FP_ADD = 3'd4,
        FU_FP_RA  = 3'd5,
        FU_VPOP   = 3'd6,
        FU_MEM    = 3'd7
    } fu_e;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_WAIT  = 2'd1,
        WR_WRITE = 2'd2
    } wr_state_e;

    // VL of zero means a full-length vector; anything past MAXVL is clamped.
    function automatic logic [LEN_W-1:0] eff_len(input logic [VL_W-1:0] vl);
        if (vl == '0 || int'(vl) > MAXVL) begin
            return LEN_W'(MAXVL);
        end
        return LEN_W'(vl);
    endfunction

endpackage

// File: rtl/v_resv_slot.sv
// One vector register's reservation tracking.
//   Write FSM (IDLE -> WAIT -> WRITE -> IDLE) sequences the result write of the
//   instruction that targets this register; a read counter covers operand reads.
// Ports:
//   clk, rst_n     clock / async active-low reset
//   i_wr_start     write reservation strobe (one cycle at issue)
//   i_rd_start     read reservation strobe (one cycle at issue)
//   i_fu_delay     FU pipeline latency of the issuing instruction
//   i_len          effective vector length (already clamped, 1..MAXVL)
//   o_busy         register reserved by a write or a read (registered)
//   o_chain_n      low only in the element-0 write cycle (registered)
//   o_elem         element index of the current result write, 0 when not writing
module v_resv_slot
    import cray_v_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_start,
    input  logic              i_rd_start,
    input  logic [DLY_W-1:0]  i_fu_delay,
    input  logic [LEN_W-1:0]  i_len,
    output logic              o_busy,
    output logic              o_chain_n,
    output logic [ELEM_W-1:0] o_elem
);

    wr_state_e         wr_state_q, wr_state_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ELEM_W-1:0] elem_q, elem_d;
    logic [LEN_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic              busy_q, busy_d;
    logic              chain_n_q, chain_n_d;
    logic              wr_last;

    // Final element of the write burst: a new write strobe here is a legal restart.
    assign wr_last = (wr_state_q == WR_WRITE) && ({1'b0, elem_q} == (len_q - 1'b1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= WR_IDLE;
            dly_q      <= '0;
            len_q      <= '0;
            elem_q     <= '0;
            rd_cnt_q   <= '0;
            busy_q     <= 1'b0;
            chain_n_q  <= 1'b1;
        end else begin
            wr_state_q <= wr_state_d;
            dly_q      <= dly_d;
            len_q      <= len_d;
            elem_q     <= elem_d;
            rd_cnt_q   <= rd_cnt_d;
            busy_q     <= busy_d;
            chain_n_q  <= chain_n_d;
        end
    end

    // Next-state logic
    always_comb begin
        wr_state_d = wr_state_q;
        dly_d      = dly_q;
        len_d      = len_q;
        elem_d     = elem_q;

        unique case (wr_state_q)
            WR_IDLE: begin
            end
            WR_WAIT: begin
                if (dly_q != '0) begin
                    dly_d = dly_q - 1'b1;
                end
                // Counter was loaded with the full delay, so leaving on 1 gives
                // exactly fu_delay WAIT cycles before element 0.
                if (dly_q <= DLY_W'(1)) begin
                    wr_state_d = WR_WRITE;
                    elem_d     = '0;
                end
            end
            WR_WRITE: begin
                if (wr_last) begin
                    wr_state_d = WR_IDLE;
                    elem_d     = '0;
                end else begin
                    elem_d = elem_q + 1'b1;
                end
            end
            default: begin
                wr_state_d = WR_IDLE;
                elem_d     = '0;
            end
        endcase

        // A strobe always wins: normal issue, restart on the last element,
        // or (illegally) overwrite of a live reservation.
        if (i_wr_start) begin
            dly_d      = i_fu_delay;
            len_d      = i_len;
            elem_d     = '0;
            wr_state_d = (i_fu_delay == '0) ? WR_WRITE : WR_WAIT;
        end

        if (i_rd_start) begin
            rd_cnt_d = i_len;
        end else if (rd_cnt_q != '0) begin
            rd_cnt_d = rd_cnt_q - 1'b1;
        end else begin
            rd_cnt_d = '0;
        end
    end

    // Output logic: computed from next state so the outputs are plain flops.
    always_comb begin
        busy_d    = (wr_state_d != WR_IDLE) || (rd_cnt_d != '0);
        chain_n_d = !((wr_state_d == WR_WRITE) && (elem_d == '0));
    end

    assign o_busy    = busy_q;
    assign o_chain_n = chain_n_q;
    assign o_elem    = elem_q;

`ifndef SYNTHESIS
    wr_overwrite_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_wr_start && (wr_state_q != WR_IDLE) && !wr_last));
    rd_overwrite_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_rd_start && (rd_cnt_q > LEN_W'(1))));
`endif

endmodule

// File: rtl/v_reservation.sv
// Vector register / functional-unit reservation tracker.
// Consumes the issue strobes of the vector scheduler and reports which
// registers and FUs are reserved, plus the per-register chain slot.
// Ports:
//   clk, rst_n        clock / async active-low reset
//   i_vwrite_start    one-hot Vi write reservation strobe
//   i_vread_start     Vj/Vk read reservation strobes (up to two bits)
//   i_vfu_start       one-hot FU reservation strobe
//   i_fu_delay        FU pipeline latency of the issuing instruction
//   i_vl              vector length, sampled at issue (0 = MAXVL)
//   o_vreg_busy       register reserved
//   o_vreg_chain_n    0 = chain slot open for that register this cycle
//   o_vfu_busy        FU reserved
//   o_vwr_elem        per-register element index of the current result write
module v_reservation
    import cray_v_pkg::*;
#(
    parameter int NREG = 8,
    parameter int NFU  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREG-1:0]          i_vwrite_start,
    input  logic [NREG-1:0]          i_vread_start,
    input  logic [NFU-1:0]           i_vfu_start,
    input  logic [DLY_W-1:0]         i_fu_delay,
    input  logic [VL_W-1:0]          i_vl,
    output logic [NREG-1:0]          o_vreg_busy,
    output logic [NREG-1:0]          o_vreg_chain_n,
    output logic [NFU-1:0]           o_vfu_busy,
    output logic [NREG*ELEM_W-1:0]   o_vwr_elem
);

    logic [LEN_W-1:0] len;

    assign len = eff_len(i_vl);

    // Per-register write/read reservation
    for (genvar r = 0; r < NREG; r++) begin : g_slot
        v_resv_slot u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_wr_start (i_vwrite_start[r]),
            .i_rd_start (i_vread_start[r]),
            .i_fu_delay (i_fu_delay),
            .i_len      (len),
            .o_busy     (o_vreg_busy[r]),
            .o_chain_n  (o_vreg_chain_n[r]),
            .o_elem     (o_vwr_elem[r*ELEM_W +: ELEM_W])
        );
    end

    // FU reservation: FUs are fully pipelined, so a unit is held for L cycles.
    logic [NFU-1:0][LEN_W-1:0] fu_cnt_q, fu_cnt_d;
    logic [NFU-1:0]            fu_busy_q, fu_busy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fu_cnt_q  <= '0;
            fu_busy_q <= '0;
        end else begin
            fu_cnt_q  <= fu_cnt_d;
            fu_busy_q <= fu_busy_d;
        end
    end

    always_comb begin
        fu_cnt_d  = fu_cnt_q;
        fu_busy_d = '0;
        for (int f = 0; f < NFU; f++) begin
            if (i_vfu_start[f]) begin
                fu_cnt_d[f] = len;
            end else if (fu_cnt_q[f] != '0) begin
                fu_cnt_d[f] = fu_cnt_q[f] - 1'b1;
            end
            fu_busy_d[f] = (fu_cnt_d[f] != '0);
        end
    end

    assign o_vfu_busy = fu_busy_q;

`ifndef SYNTHESIS
    for (genvar f = 0; f < NFU; f++) begin : g_fu_chk
        fu_overwrite_a: assert property (@(posedge clk) disable iff (!rst_n)
            !(i_vfu_start[f] && (fu_cnt_q[f] > LEN_W'(1))));
    end
`endif

endmodule

// File: doc/v_reservation.md
Name: v_reservation

Overview:
- Tracks per-register and per-functional-unit reservations for the vector datapath.
- Consumes the start strobes (write/read/FU, one-hot) and FU delay produced at vector instruction issue.
- Produces busy and chain-slot status that gates issue of the next vector instruction.
- Sits directly downstream of the vector scheduler; its outputs feed back as the scheduler's i_vreg_busy, i_vreg_chain_n and i_vfu_busy.

Parameters:
- NREG, 8, number of V registers (one-hot width of register strobes).
- NFU, 8, number of vector functional units (one-hot width of FU strobes).
- VL_W, 7, vector-length input width.
- MAXVL, 64, maximum vector length; VL=0 is interpreted as MAXVL.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- i_vwrite_start  in  NREG  one-hot Vi write reservation strobe, valid for one cycle at issue.
- i_vread_start  in  NREG  Vj/Vk read reservation strobes (up to 2 bits set).
- i_vfu_start  in  NFU  one-hot FU reservation strobe.
- i_fu_delay  in  4  FU pipeline latency of the issuing instruction, 0..15.
- i_vl  in  VL_W  current vector length; sampled at issue.
- o_vreg_busy  out  NREG  register reserved (read or write in progress).
- o_vreg_chain_n  out  NREG  0 = chain slot open for that register this cycle.
- o_vfu_busy  out  NFU  FU reserved.
- o_vwr_elem  out  NREG*6  per-register element index of the current result write (for the register-file write port).

Behaviour:
- One clock domain, clk; reset is asynchronous and active-low (rst_n).
- Reset: all counters 0, all states IDLE; o_vreg_busy=0, o_vfu_busy=0, o_vreg_chain_n=all 1s, o_vwr_elem=0.
- Reset asserted mid-operation aborts every reservation immediately (async), with no residual busy.
- All outputs are registered. A strobe in cycle N first affects outputs in cycle N+1.
- Effective length L = (i_vl==0 || i_vl>MAXVL) ? MAXVL : i_vl, latched per register/FU at its strobe.
- Write FSM, per register, states IDLE -> WAIT -> WRITE -> IDLE:
  - IDLE + write strobe: load delay counter with i_fu_delay, element counter with L.
  - If i_fu_delay==0, go straight to WRITE; otherwise go to WAIT.
  - WAIT: decrement the delay counter; go to WRITE in the cycle it reaches 0.
  - WRITE: o_vwr_elem counts 0..L-1, one per cycle; return to IDLE after element L-1.
  - Timing: busy high for cycles N+1 .. N+fu_delay+L.
  - Chain slot: chain_n=0 for exactly one cycle, N+fu_delay+1 (the element-0 write cycle); chain_n=1 otherwise.
- Read counter, per register: loaded with L on a read strobe; busy high for cycles N+1 .. N+L. Reads never open a chain slot.
- o_vreg_busy[r] = write-busy[r] | read-busy[r].
- Same register with write and read strobe in the same cycle (Vi==Vj): both reservations run; busy until the later one ends; the chain slot still comes from the write FSM.
- Two read strobes to one register collapse into one reservation.
- FU counter: loaded with L on its strobe; busy high for cycles N+1 .. N+L (pipelined, one element per clock).
- Strobe to a register or FU already busy is illegal (the scheduler prevents it). If it happens, the new reservation overwrites the old one and a simulation-only assertion fires.
- A strobe arriving in the same cycle a reservation ends is legal: the new reservation starts with no idle gap.
- Counters saturate at 0; wrap-around is not possible.

Decomposition:
- Shared package cray_v_pkg: FU encodings (VLOG=0, VSHIFT=1, VADD=2, FP_MUL=3, FP_ADD=4, FP_RA=5, VPOP=6, MEM=7), MAXVL, VL_W, and the write-FSM state enum.
- Sub-module v_resv_slot: one register's write FSM, read counter and chain logic, instantiated NREG times.
- FU counters are simple enough to generate inline.

Test Plan:
- VL=64, write start V3 with fu_delay=3 at cycle 10 -> busy[3]=1 for cycles 11..77; chain_n[3]=0 only at cycle 14; o_vwr_elem[3] = 0 at 14, 63 at 77.
- VL=5, read start V1|V2 and FU start bit2 at cycle 0 -> busy[1], busy[2] and vfu_busy[2] high for cycles 1..5, low at 6.
- VL=0, write V0 with fu_delay=0 -> chain at cycle N+1, busy through N+64 (MAXVL rule).
- Same-cycle write V4 (delay 6, VL=8) and read V4 -> busy[4] through N+14; chain_n[4]=0 only at N+7.
- Back-to-back: FU start bit7, VL=4 at cycle 0 and again at cycle 4 -> vfu_busy[7] continuous 1..8, with no gap.
- rst_n pulsed low at cycle 20 of a VL=64 write -> all outputs reach reset values immediately; no busy after release.
